// File: rtl/map_color_checker.sv
// map_color_checker: read-only walker over the map memory. Compares each
// area's colour against all of its neighbours, reports the conflict count and
// the first conflicting pair, and looks up the 7-segment digit for the count.
// Optional feature macro: MAP_CHECKER_SEG_EN (adds the LED lookup state and
// the seg register; otherwise seg is tied to blank 8'hFF).
module map_color_checker #(
   parameter int N_AREAS    = 23,
   parameter int COLOR_BASE = 0,
   parameter int IDX_BASE   = 23,
   parameter int LED_BASE   = 159
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rdata,
   output logic [7:0] conflict_cnt,
   output logic       first_valid,
   output logic [7:0] first_a,
   output logic [7:0] first_b,
   output logic [7:0] seg
);

   localparam logic [7:0] N_A   = 8'(N_AREAS);
   localparam logic [7:0] COL_B = 8'(COLOR_BASE);
   localparam logic [7:0] IDX_B = 8'(IDX_BASE);
   localparam logic [7:0] LED_B = 8'(LED_BASE);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_BEG,
      S_LD_END,
      S_LD_COL,
      S_LD_NB,
      S_LD_NCOL,
      S_NEXT,
      S_LD_LED,
      S_DONE
   } state_t;

   state_t     state_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] mem_addr_q;
   logic [7:0] cnt_q;
   logic       first_valid_q;
   logic [7:0] first_a_q;
   logic [7:0] first_b_q;
   logic [7:0] area_q;
   logic [7:0] ptr_q;
   logic [7:0] lst_end_q;
   logic [7:0] mycol_q;
   logic [7:0] nb_q;

   logic [7:0] ptr_inc_d;
   logic [7:0] area_inc_d;
   logic [7:0] digit_d;
   logic       conflict_d;

   // Derived values shared by several states.
   always_comb begin
      ptr_inc_d  = ptr_q + 8'd1;
      area_inc_d = area_q + 8'd1;
      digit_d    = (cnt_q > 8'd9) ? 8'd9 : cnt_q;
      conflict_d = (mem_rdata == mycol_q) && (mycol_q != 8'd0);
   end

`ifdef MAP_CHECKER_SEG_EN
   logic [7:0] seg_q;
`endif

   // Walker FSM: every state consumes the address registered on its entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mem_addr_q    <= '0;
         cnt_q         <= '0;
         first_valid_q <= 1'b0;
         first_a_q     <= '0;
         first_b_q     <= '0;
         area_q        <= '0;
         ptr_q         <= '0;
         lst_end_q     <= '0;
         mycol_q       <= '0;
         nb_q          <= '0;
`ifdef MAP_CHECKER_SEG_EN
         seg_q         <= 8'hFF;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  area_q        <= '0;
                  cnt_q         <= '0;
                  first_valid_q <= 1'b0;
                  mem_addr_q    <= IDX_B;
                  busy_q        <= 1'b1;
                  state_q       <= S_LD_BEG;
               end
            end
            S_LD_BEG: begin
               ptr_q      <= mem_rdata;
               mem_addr_q <= IDX_B + area_q + 8'd1;
               state_q    <= S_LD_END;
            end
            S_LD_END: begin
               lst_end_q  <= mem_rdata;
               mem_addr_q <= COL_B + area_q;
               state_q    <= S_LD_COL;
            end
            S_LD_COL: begin
               mycol_q <= mem_rdata;
               if (ptr_q == lst_end_q) begin
                  state_q <= S_NEXT;
               end else begin
                  mem_addr_q <= ptr_q;
                  state_q    <= S_LD_NB;
               end
            end
            S_LD_NB: begin
               nb_q       <= mem_rdata;
               mem_addr_q <= COL_B + mem_rdata;
               state_q    <= S_LD_NCOL;
            end
            S_LD_NCOL: begin
               if (conflict_d) begin
                  if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                  if (!first_valid_q) begin
                     first_valid_q <= 1'b1;
                     first_a_q     <= area_q;
                     first_b_q     <= nb_q;
                  end
               end
               ptr_q <= ptr_inc_d;
               if (ptr_inc_d == lst_end_q) begin
                  state_q <= S_NEXT;
               end else begin
                  mem_addr_q <= ptr_inc_d;
                  state_q    <= S_LD_NB;
               end
            end
            S_NEXT: begin
               area_q <= area_inc_d;
               if (area_inc_d == N_A) begin
                  // LED address is also issued without the seg lookup; it is
                  // harmless there because the port is released in DONE.
                  mem_addr_q <= LED_B + digit_d;
`ifdef MAP_CHECKER_SEG_EN
                  state_q    <= S_LD_LED;
`else
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= S_DONE;
`endif
               end else begin
                  mem_addr_q <= IDX_B + area_inc_d;
                  state_q    <= S_LD_BEG;
               end
            end
            S_LD_LED: begin
`ifdef MAP_CHECKER_SEG_EN
               seg_q   <= mem_rdata;
`endif
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               mem_addr_q <= '0;
               state_q    <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign mem_addr     = mem_addr_q;
   assign conflict_cnt = cnt_q;
   assign first_valid  = first_valid_q;
   assign first_a      = first_a_q;
   assign first_b      = first_b_q;
`ifdef MAP_CHECKER_SEG_EN
   assign seg          = seg_q;
`else
   assign seg          = 8'hFF;
`endif

endmodule

// File: tb/tb_map_color_checker.sv
// tb_map_color_checker: directed bench for map_color_checker with a
// behavioural map memory (23 areas, 56 symmetric edges, LED table at 159).
module tb_map_color_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] conflict_cnt;
   logic       first_valid;
   logic [7:0] first_a;
   logic [7:0] first_b;
   logic [7:0] seg;

   logic [7:0] mem [256];
   logic [7:0] led_tab [10];

   int n_pass  = 0;
   int n_total = 0;

`ifdef MAP_CHECKER_SEG_EN
   localparam int BUSY_EXP = 317;
`else
   localparam int BUSY_EXP = 316;
`endif

   int r_busy, r_done, r_done_busy, r_cnt, r_fv, r_fa, r_fb, r_seg;

   typedef struct {
      string name;
      int    mode;     // colour pattern selector
      int    cnt;
      int    fv;
      int    fa;
      int    fb;
      int    digit;
   } vec_t;

   vec_t vecs [5];

   map_color_checker #(
      .N_AREAS   (23),
      .COLOR_BASE(0),
      .IDX_BASE  (23),
      .LED_BASE  (159)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .conflict_cnt(conflict_cnt),
      .first_valid (first_valid),
      .first_a     (first_a),
      .first_b     (first_b),
      .seg         (seg)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic int exp_seg(input int digit);
`ifdef MAP_CHECKER_SEG_EN
      return int'(led_tab[digit]);
`else
      return (digit >= 0) ? 32'hFF : 32'hFF;
`endif
   endfunction

   // Neighbours of a: a+-1, a+-2 always; a+-3 only when the lower end is <= 12.
   task automatic build_map();
      int ptr;
      int d [6];
      d = '{-3, -2, -1, 1, 2, 3};
      for (int i = 0; i < 256; i++) mem[i] = 8'd0;
      ptr = 47;
      for (int a = 0; a < 23; a++) begin
         mem[23 + a] = 8'(ptr);
         for (int k = 0; k < 6; k++) begin
            int b;
            b = a + d[k];
            if (b >= 0 && b < 23 && (d[k] * d[k] < 9 || (a < b ? a : b) <= 12)) begin
               mem[ptr] = 8'(b);
               ptr++;
            end
         end
      end
      mem[23 + 23] = 8'(ptr);
      led_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      for (int i = 0; i < 10; i++) mem[159 + i] = led_tab[i];
   endtask

   task automatic set_colours(input int mode);
      for (int a = 0; a < 23; a++) begin
         case (mode)
            0: mem[a] = 8'd0;
            1: mem[a] = (a < 2) ? 8'd1 : 8'd0;
            2: mem[a] = 8'((a % 4) + 1);
            3: mem[a] = (a == 21) ? 8'd3 : 8'((a % 4) + 1);
            default: mem[a] = 8'd1;
         endcase
      end
   endtask

   // Starts a walk and follows it until one cycle after done (bounded).
   task automatic run_walk(input int p1, input int p2, input int p3);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      r_busy = 0; r_done = 0; r_done_busy = 0;
      for (int i = 0; i < 2000; i++) begin
         if (busy) r_busy++;
         if (done) begin
            r_done++;
            if (busy) r_done_busy++;
            r_cnt = int'(conflict_cnt); r_fv = int'(first_valid);
            r_fa  = int'(first_a);      r_fb = int'(first_b);
            r_seg = int'(seg);
         end else if (r_done > 0) begin
            break;
         end
         start = (i == p1 || i == p2 || i == p3);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"},  int'(busy), 0);
      check({tag, " done"},  int'(done), 0);
      check({tag, " addr"},  int'(mem_addr), 0);
      check({tag, " cnt"},   int'(conflict_cnt), 0);
      check({tag, " fv"},    int'(first_valid), 0);
      check({tag, " fa"},    int'(first_a), 0);
      check({tag, " fb"},    int'(first_b), 0);
      check({tag, " seg"},   int'(seg), 32'hFF);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen_busy, seen_done;

      vecs[0] = '{"zero",   0,   0, 0,  0,  0, 0};
      vecs[1] = '{"pair01", 1,   2, 1,  0,  1, 2};
      vecs[2] = '{"valid4", 2,   0, 0,  0,  0, 0};
      vecs[3] = '{"c21_22", 3,   2, 1, 21, 22, 2};
      vecs[4] = '{"allone", 4, 112, 1,  0,  1, 9};

      rst_n = 1'b0;
      start = 1'b0;
      build_map();
      set_colours(0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("rst");

      for (int v = 0; v < 5; v++) begin
         set_colours(vecs[v].mode);
         run_walk(-1, -1, -1);
         check({vecs[v].name, " done_cycles"}, r_done, 1);
         check({vecs[v].name, " done_busy"}, r_done_busy, 0);
         check({vecs[v].name, " busy_cycles"}, r_busy, BUSY_EXP);
         check({vecs[v].name, " cnt"}, r_cnt, vecs[v].cnt);
         check({vecs[v].name, " fv"}, r_fv, vecs[v].fv);
         if (vecs[v].fv != 0) begin
            check({vecs[v].name, " fa"}, r_fa, vecs[v].fa);
            check({vecs[v].name, " fb"}, r_fb, vecs[v].fb);
         end
         check({vecs[v].name, " seg"}, r_seg, exp_seg(vecs[v].digit));
         check({vecs[v].name, " hold_cnt"}, int'(conflict_cnt), vecs[v].cnt);
      end

      // start pulses during the walk must not restart or stretch it
      set_colours(4);
      run_walk(10, 150, 300);
      check("ign_start done_cycles", r_done, 1);
      check("ign_start busy_cycles", r_busy, BUSY_EXP);
      check("ign_start cnt", r_cnt, 112);
      repeat (3) @(negedge clk);
      check("ign_start idle_after", int'(busy), 0);

      // reset about 50 cycles into a walk aborts it
      set_colours(4);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (49) @(negedge clk);
      check("midrst busy_before", int'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      rst_n = 1'b1;
      seen_busy = 0; seen_done = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy) seen_busy++;
         if (done) seen_done++;
      end
      check("midrst no_done", seen_done, 0);
      check("midrst no_busy", seen_busy, 0);

      // start held high through DONE is re-accepted in the next IDLE cycle
      set_colours(1);
      @(negedge clk); start = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done) begin seen_done = 1; break; end
      end
      check("hold done_seen", seen_done, 1);
      @(negedge clk);
      check("hold idle_gap_busy", int'(busy), 0);
      @(negedge clk);
      check("hold restart_busy", int'(busy), 1);
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
